ibex_pmp_chk_arbiter: RTL and testbench
=======================================

IBEX_PMP_CHK_ARBITER -- requirements
Module: ibex_pmp_chk_arbiter

Interface
REQ-001 Parameter PMPNumReq, default 2, SHALL set the number of requesters sharing one PMP check channel (legal 2..8).
REQ-002 Port clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port req_valid_i  input  [PMPNumReq]  SHALL flag a pending check request per requester.
REQ-005 Port req_ready_o  output  [PMPNumReq]  SHALL be the one-cycle acceptance pulse per requester.
REQ-006 Port req_addr_i  input  [PMPNumReq] x 34  SHALL be the physical address to check.
REQ-007 Port req_type_i  input  [PMPNumReq] x ibex_pkg::pmp_req_e  SHALL be the access type.
REQ-008 Port req_priv_i  input  [PMPNumReq] x ibex_pkg::priv_lvl_e  SHALL be the privilege level.
REQ-009 Port rsp_valid_o  output  [PMPNumReq]  SHALL be the one-cycle result pulse per requester.
REQ-010 Port rsp_err_o  output  [PMPNumReq]  SHALL be the access-fault result, qualified by rsp_valid_o.
REQ-011 Port chk_addr_o / chk_type_o / chk_priv_o  output  34 / pmp_req_e / priv_lvl_e  SHALL drive one PMP checker channel.
REQ-012 Port chk_err_i  input  1  SHALL be the checker's combinational fault result for the chk_* inputs.
REQ-013 Port csr_pmp_wr_i  input  1  SHALL flag a write to any PMP cfg/addr/mseccfg CSR this cycle.
REQ-014 Port busy_o  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CHECK, RESP.
REQ-016 In IDLE or RESP, if any req_valid_i is high, the arbiter SHALL grant exactly one requester, pulse its req_ready_o, capture its addr/type/priv into the chk_* registers, record it as owner, and enter CHECK next cycle.
REQ-017 req_ready_o SHALL be combinational from current state and req_valid_i; never asserted for a requester with req_valid_i low, and never in CHECK.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod PMPNumReq; last_grant updates only on a grant.
REQ-019 In CHECK with csr_pmp_wr_i low, chk_err_i SHALL be registered into err_q and the FSM SHALL enter RESP.
REQ-020 In CHECK with csr_pmp_wr_i high, the sample SHALL be discarded and the FSM SHALL remain in CHECK (re-check against updated config); repeated writes stall indefinitely.
REQ-021 In RESP, rsp_valid_o[owner] SHALL be 1 and rsp_err_o[owner] SHALL equal err_q; all other rsp bits 0; csr_pmp_wr_i SHALL have no effect.
REQ-022 RESP with no valid request SHALL return to IDLE; with a grant it SHALL go to CHECK (back-to-back, one result per 2 cycles).
REQ-023 Latency: request accepted in cycle N SHALL produce rsp_valid_o in cycle N+2 absent csr_pmp_wr_i in CHECK.
REQ-024 rsp_err_o[i] SHALL be 0 whenever rsp_valid_o[i] is 0.
REQ-025 chk_* outputs SHALL be registered and hold their captured value until the next grant.
REQ-026 Requesters SHALL hold req_valid_i and payload stable until req_ready_o; payload changes after acceptance SHALL not affect the in-flight check.

Reset
REQ-027 On rst_i: state IDLE, last_grant = PMPNumReq-1 (requester 0 wins first), chk_addr_o = 0, chk_type_o = PMP_ACC_EXEC, chk_priv_o = PRIV_LVL_M, err_q = 0, owner = 0, busy_o = 0, all rsp_valid_o/rsp_err_o/req_ready_o = 0.
REQ-028 Reset asserted mid-operation SHALL drop the in-flight request with no response emitted.

Verification
REQ-029 Single request: req_valid_i[1]=1, addr 34'h0_8000_0000, chk_err_i=1 -> req_ready_o[1] in cycle N, rsp_valid_o[1]=1, rsp_err_o[1]=1 in N+2, busy_o high N+1..N+2.
REQ-030 Contention: both requesters valid continuously after reset -> grants 0,1,0,1 every 2 cycles; responses routed to matching owner.
REQ-031 CSR write: csr_pmp_wr_i=1 for 2 cycles during CHECK, chk_err_i changing 1->0 -> response delayed 2 cycles, rsp_err_o=0.
REQ-032 CSR write in RESP cycle -> response unchanged, no extra delay.
REQ-033 Reset in CHECK -> no rsp_valid_o pulse; next request after reset granted to requester 0 first with N+2 latency.
REQ-034 Payload change after ready: req_addr_i altered in N+1 -> chk_addr_o keeps captured value through RESP.

Source files
------------

// File: rtl/ibex_pmp_chk_arbiter.sv
// Round-robin arbiter sharing one combinational PMP checker between several requesters.
// Each accepted request is checked once (re-checked while PMP CSRs are being written) and answered by a result pulse.
package ibex_pkg;
    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        PRIV_LVL_M = 2'b11,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_U = 2'b00
    } priv_lvl_e;
endpackage

// Handshake: requester i holds req_valid_i[i] and its payload until the cycle
// req_ready_o[i] is high; that cycle is the transfer. The result is the single
// cycle in which rsp_valid_o[i] is high, with rsp_err_o[i] meaningful only then.
module ibex_pmp_chk_arbiter #(
    parameter int PMPNumReq = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [PMPNumReq-1:0]                  req_valid_i,
    output logic [PMPNumReq-1:0]                  req_ready_o,
    input  logic [PMPNumReq-1:0][33:0]            req_addr_i,
    input  ibex_pkg::pmp_req_e [PMPNumReq-1:0]    req_type_i,
    input  ibex_pkg::priv_lvl_e [PMPNumReq-1:0]   req_priv_i,
    output logic [PMPNumReq-1:0]                  rsp_valid_o,
    output logic [PMPNumReq-1:0]                  rsp_err_o,
    output logic [33:0]                           chk_addr_o,
    output ibex_pkg::pmp_req_e                    chk_type_o,
    output ibex_pkg::priv_lvl_e                   chk_priv_o,
    input  logic                                  chk_err_i,
    input  logic                                  csr_pmp_wr_i,
    output logic                                  busy_o,
    output logic [1:0]                            dbg_state_o
);
    localparam int IdxW = $clog2(PMPNumReq);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_RESP  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     last_grant_q, last_grant_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic                err_q, err_d;
    logic [33:0]         chk_addr_q, chk_addr_d;
    ibex_pkg::pmp_req_e  chk_type_q, chk_type_d;
    ibex_pkg::priv_lvl_e chk_priv_q, chk_priv_d;

    logic                grant_found;
    logic [IdxW-1:0]     grant_idx;
    logic                can_grant;

    // Scan starts one past the last winner so every requester is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < PMPNumReq; k++) begin
            if (!grant_found && req_valid_i[(int'(last_grant_q) + 1 + k) % PMPNumReq]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'((int'(last_grant_q) + 1 + k) % PMPNumReq);
            end
        end
    end

    assign can_grant = (state_q != S_CHECK) && grant_found;

    always_comb begin
        req_ready_o = '0;
        if (can_grant) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        err_d        = err_q;
        chk_addr_d   = chk_addr_q;
        chk_type_d   = chk_type_q;
        chk_priv_d   = chk_priv_q;
        case (state_q)
            S_CHECK: begin
                // A concurrent PMP CSR write may change the verdict, so the sample is discarded.
                if (!csr_pmp_wr_i) begin
                    err_d   = chk_err_i;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (can_grant) begin
                    state_d      = S_CHECK;
                    last_grant_d = grant_idx;
                    owner_d      = grant_idx;
                    chk_addr_d   = req_addr_i[grant_idx];
                    chk_type_d   = req_type_i[grant_idx];
                    chk_priv_d   = req_priv_i[grant_idx];
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_err_o   = '0;
        if (state_q == S_RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
            rsp_err_o[owner_q]   = err_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= IdxW'(PMPNumReq - 1);
            owner_q      <= '0;
            err_q        <= 1'b0;
            chk_addr_q   <= '0;
            chk_type_q   <= ibex_pkg::PMP_ACC_EXEC;
            chk_priv_q   <= ibex_pkg::PRIV_LVL_M;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            chk_addr_q   <= chk_addr_d;
            chk_type_q   <= chk_type_d;
            chk_priv_q   <= chk_priv_d;
        end
    end

    assign chk_addr_o  = chk_addr_q;
    assign chk_type_o  = chk_type_q;
    assign chk_priv_o  = chk_priv_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ibex_pmp_chk_arbiter.sv
// Directed bench for ibex_pmp_chk_arbiter with two requesters; inputs change 1 time unit
// after each rising edge and outputs are sampled 1 unit later.
module tb_ibex_pmp_chk_arbiter;
    logic                            clk;
    logic                            rst;
    logic [1:0]                      req_valid;
    logic [1:0]                      req_ready;
    logic [1:0][33:0]                req_addr;
    ibex_pkg::pmp_req_e [1:0]        req_type;
    ibex_pkg::priv_lvl_e [1:0]       req_priv;
    logic [1:0]                      rsp_valid;
    logic [1:0]                      rsp_err;
    logic [33:0]                     chk_addr;
    ibex_pkg::pmp_req_e              chk_type;
    ibex_pkg::priv_lvl_e             chk_priv;
    logic                            chk_err;
    logic                            csr_wr;
    logic                            busy;
    logic [1:0]                      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    ibex_pmp_chk_arbiter #(.PMPNumReq(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_type_i   (req_type),
        .req_priv_i   (req_priv),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .chk_addr_o   (chk_addr),
        .chk_type_o   (chk_type),
        .chk_priv_o   (chk_priv),
        .chk_err_i    (chk_err),
        .csr_pmp_wr_i (csr_wr),
        .busy_o       (busy),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_addr  = '0;
        req_type[0] = ibex_pkg::PMP_ACC_WRITE;
        req_type[1] = ibex_pkg::PMP_ACC_READ;
        req_priv[0] = ibex_pkg::PRIV_LVL_S;
        req_priv[1] = ibex_pkg::PRIV_LVL_U;
        chk_err   = 1'b0;
        csr_wr    = 1'b0;

        // reset values
        tick();
        settle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(chk_addr), 64'd0);
        check("rst_type", 64'(chk_type), 64'(ibex_pkg::PMP_ACC_EXEC));
        check("rst_priv", 64'(chk_priv), 64'(ibex_pkg::PRIV_LVL_M));
        check("rst_rsp_v", 64'(rsp_valid), 64'd0);
        check("rst_rsp_e", 64'(rsp_err), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;

        // single request on requester 1, faulting
        req_valid   = 2'b10;
        req_addr[1] = 34'h0_8000_0000;
        settle();
        check("t1_ready", 64'(req_ready), 64'b10);
        check("t1_busy_n", 64'(busy), 64'd0);
        tick();
        req_valid = 2'b00;
        chk_err   = 1'b1;
        settle();
        check("t1_busy_n1", 64'(busy), 64'd1);
        check("t1_addr", 64'(chk_addr), 64'h0_8000_0000);
        check("t1_type", 64'(chk_type), 64'(ibex_pkg::PMP_ACC_READ));
        check("t1_priv", 64'(chk_priv), 64'(ibex_pkg::PRIV_LVL_U));
        check("t1_rsp_v_n1", 64'(rsp_valid), 64'd0);
        tick();
        chk_err = 1'b0;
        settle();
        check("t1_rsp_v", 64'(rsp_valid), 64'b10);
        check("t1_rsp_e", 64'(rsp_err), 64'b10);
        check("t1_busy_n2", 64'(busy), 64'd1);
        tick();
        settle();
        check("t1_busy_n3", 64'(busy), 64'd0);
        check("t1_rsp_v_n3", 64'(rsp_valid), 64'd0);
        check("t1_rsp_e_n3", 64'(rsp_err), 64'd0);

        // contention: both valid continuously after reset
        do_reset();
        req_addr[0] = 34'h100;
        req_addr[1] = 34'h200;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            req_valid = 2'b11;
            settle();
            check("cont_ready", 64'(req_ready), 64'(1 << g));
            if (k > 0) begin
                check("cont_rsp_v", 64'(rsp_valid), 64'(1 << (1 - g)));
                check("cont_rsp_e", 64'(rsp_err), (g == 1) ? 64'b01 : 64'b00);
            end
            tick();
            chk_err = (g == 0);
            settle();
            check("cont_addr", 64'(chk_addr), (g == 0) ? 64'h100 : 64'h200);
            check("cont_ready_chk", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = 2'b00;
        settle();
        check("cont_last_v", 64'(rsp_valid), 64'b10);
        check("cont_last_e", 64'(rsp_err), 64'b00);
        check("cont_last_rdy", 64'(req_ready), 64'd0);
        tick();
        settle();
        check("cont_idle", 64'(busy), 64'd0);

        // CSR write for two cycles during CHECK, then CSR write during RESP
        chk_err     = 1'b0;
        req_valid   = 2'b01;
        req_addr[0] = 34'h300;
        settle();
        check("csr_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b10;
        csr_wr    = 1'b1;
        chk_err   = 1'b1;
        settle();
        check("csr_rdy_chk1", 64'(req_ready), 64'd0);
        check("csr_rsp_n1", 64'(rsp_valid), 64'd0);
        check("csr_busy_n1", 64'(busy), 64'd1);
        tick();
        settle();
        check("csr_rsp_n2", 64'(rsp_valid), 64'd0);
        check("csr_rdy_chk2", 64'(req_ready), 64'd0);
        tick();
        csr_wr  = 1'b0;
        chk_err = 1'b0;
        settle();
        check("csr_rsp_n3", 64'(rsp_valid), 64'd0);
        tick();
        settle();
        check("csr_rsp_v", 64'(rsp_valid), 64'b01);
        check("csr_rsp_e", 64'(rsp_err), 64'b00);
        check("csr_b2b_rdy", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        chk_err   = 1'b1;
        settle();
        check("csr_b2b_addr", 64'(chk_addr), 64'h200);
        tick();
        csr_wr  = 1'b1;
        chk_err = 1'b0;
        settle();
        check("csr_resp_v", 64'(rsp_valid), 64'b10);
        check("csr_resp_e", 64'(rsp_err), 64'b10);
        tick();
        csr_wr = 1'b0;
        settle();
        check("csr_resp_idle", 64'(busy), 64'd0);
        check("csr_resp_gone", 64'(rsp_valid), 64'd0);

        // reset while a check is in flight
        req_valid   = 2'b01;
        req_addr[0] = 34'h400;
        settle();
        check("rc_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        chk_err   = 1'b1;
        settle();
        check("rc_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        settle();
        check("rc_busy_rst", 64'(busy), 64'd0);
        check("rc_rsp_rst", 64'(rsp_valid), 64'd0);
        check("rc_addr_rst", 64'(chk_addr), 64'd0);
        tick();
        settle();
        check("rc_no_rsp", 64'(rsp_valid), 64'd0);
        rst       = 1'b0;
        req_valid = 2'b11;
        settle();
        check("rc_first_rdy", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        chk_err   = 1'b1;
        settle();
        check("rc_addr", 64'(chk_addr), 64'h400);
        tick();
        chk_err = 1'b0;
        settle();
        check("rc_rsp_v", 64'(rsp_valid), 64'b01);
        check("rc_rsp_e", 64'(rsp_err), 64'b01);
        tick();
        settle();
        check("rc_idle", 64'(busy), 64'd0);

        // payload altered after acceptance
        req_valid   = 2'b10;
        req_addr[1] = 34'h1234;
        settle();
        check("pl_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid   = 2'b00;
        req_addr[1] = 34'h3_FFFF_FFFF;
        settle();
        check("pl_addr_n1", 64'(chk_addr), 64'h1234);
        tick();
        settle();
        check("pl_addr_n2", 64'(chk_addr), 64'h1234);
        check("pl_rsp_v", 64'(rsp_valid), 64'b10);
        check("pl_rsp_e", 64'(rsp_err), 64'b00);
        tick();
        settle();
        check("pl_addr_hold", 64'(chk_addr), 64'h1234);
        check("pl_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
